// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants and types for the key tracker.
//   - ASCII codes recognised by the byte decoder
//   - bit index of each key inside the held-key vector (W is the MSB)
//   - default hold time and timer width
//   - byte classification enum and decode result struct
//   - decode_byte(): maps one received byte to a key mask / ESC / unknown
// ---------------------------------------------------------------------------
package key_pkg;

    // Timer geometry and default hold time (50 ms at 100 MHz)
    localparam int TIMER_W             = 24;
    localparam int NUM_KEYS            = 8;
    localparam int HOLD_CYCLES_DEFAULT = 5_000_000;

    typedef logic [TIMER_W-1:0]  timer_t;
    typedef logic [NUM_KEYS-1:0] key_vec_t;

    // Bit positions in the held-key vector
    localparam int KEY_W     = 7;
    localparam int KEY_S     = 6;
    localparam int KEY_A     = 5;
    localparam int KEY_D     = 4;
    localparam int KEY_J     = 3;
    localparam int KEY_K     = 2;
    localparam int KEY_L     = 1;
    localparam int KEY_SPACE = 0;

    // ASCII codes
    localparam logic [7:0] ASCII_W_LO  = 8'h77;
    localparam logic [7:0] ASCII_W_UP  = 8'h57;
    localparam logic [7:0] ASCII_S_LO  = 8'h73;
    localparam logic [7:0] ASCII_S_UP  = 8'h53;
    localparam logic [7:0] ASCII_A_LO  = 8'h61;
    localparam logic [7:0] ASCII_A_UP  = 8'h41;
    localparam logic [7:0] ASCII_D_LO  = 8'h64;
    localparam logic [7:0] ASCII_D_UP  = 8'h44;
    localparam logic [7:0] ASCII_J_LO  = 8'h6A;
    localparam logic [7:0] ASCII_J_UP  = 8'h4A;
    localparam logic [7:0] ASCII_K_LO  = 8'h6B;
    localparam logic [7:0] ASCII_K_UP  = 8'h4B;
    localparam logic [7:0] ASCII_L_LO  = 8'h6C;
    localparam logic [7:0] ASCII_L_UP  = 8'h4C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;

    // What a received byte means to the tracker
    typedef enum logic [1:0] {
        BYTE_UNKNOWN = 2'd0,
        BYTE_KEY     = 2'd1,
        BYTE_ESC     = 2'd2
    } byte_kind_t;

    typedef struct packed {
        byte_kind_t kind;
        key_vec_t   mask;
    } decode_t;

    // Upper and lower case letters select the same key; the mask is
    // one-hot for BYTE_KEY and zero otherwise.
    function automatic decode_t decode_byte(input logic [7:0] b);
        decode_t d;
        d.kind = BYTE_UNKNOWN;
        d.mask = '0;
        case (b)
            ASCII_W_LO, ASCII_W_UP: begin d.kind = BYTE_KEY; d.mask[KEY_W]     = 1'b1; end
            ASCII_S_LO, ASCII_S_UP: begin d.kind = BYTE_KEY; d.mask[KEY_S]     = 1'b1; end
            ASCII_A_LO, ASCII_A_UP: begin d.kind = BYTE_KEY; d.mask[KEY_A]     = 1'b1; end
            ASCII_D_LO, ASCII_D_UP: begin d.kind = BYTE_KEY; d.mask[KEY_D]     = 1'b1; end
            ASCII_J_LO, ASCII_J_UP: begin d.kind = BYTE_KEY; d.mask[KEY_J]     = 1'b1; end
            ASCII_K_LO, ASCII_K_UP: begin d.kind = BYTE_KEY; d.mask[KEY_K]     = 1'b1; end
            ASCII_L_LO, ASCII_L_UP: begin d.kind = BYTE_KEY; d.mask[KEY_L]     = 1'b1; end
            ASCII_SPACE:            begin d.kind = BYTE_KEY; d.mask[KEY_SPACE] = 1'b1; end
            ASCII_ESC:              begin d.kind = BYTE_ESC; end
            default:                begin d.kind = BYTE_UNKNOWN; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_hold_timer.sv
// ---------------------------------------------------------------------------
// key_hold_timer
// Hold timer for a single key. A load restarts the countdown at HOLD_CYCLES,
// otherwise the timer counts down to zero and stays there. The key bit is
// high whenever the post-update timer value is nonzero, so a load on edge N
// keeps the key high for exactly HOLD_CYCLES cycles.
//
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous active-high reset, no pulses generated
//   load          : restart the hold time this edge
//   clear         : force the timer to zero this edge (ESC)
//   key           : registered held state
//   press         : one-cycle pulse on key 0->1
//   release_pulse : one-cycle pulse on key 1->0
//                   ("release" is a reserved word, hence the longer name)
// ---------------------------------------------------------------------------
module key_hold_timer
    import key_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic key,
    output logic press,
    output logic release_pulse
);

    localparam timer_t HOLD_LOAD = timer_t'(HOLD_CYCLES);

    timer_t timer;
    timer_t timer_next;
    logic   key_next;

    // Load has priority over the decrement, so a reload landing on the
    // expiry edge keeps the key up with no release pulse. Clear and load
    // never arrive together because only one byte is decoded per cycle.
    always_comb begin
        timer_next = timer;
        if (clear) begin
            timer_next = '0;
        end else if (load) begin
            timer_next = HOLD_LOAD;
        end else if (timer != '0) begin
            timer_next = timer - timer_t'(1);
        end
        key_next = (timer_next != '0);
    end

    // Edge pulses are derived from the old and new key state, so they line
    // up with the edge on which key itself changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer         <= '0;
            key           <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            timer         <= timer_next;
            key           <= key_next;
            press         <= key_next & ~key;
            release_pulse <= ~key_next & key;
        end
    end

endmodule

// File: rtl/key_tracker.sv
// ---------------------------------------------------------------------------
// key_tracker
// Turns a stream of ASCII bytes from a UART into a held-key vector. Each
// mapped byte (re)starts that key's hold timer; ESC drops every key at once;
// any other byte is flagged on the unknown output and otherwise ignored.
//
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous active-high reset
//   rx_data[7:0]  : received byte
//   rx_valid      : one-cycle strobe qualifying rx_data
//   key[7:0]      : held keys {W,S,A,D,J,K,L,SPACE}
//   press[7:0]    : per-key pulse on 0->1
//   release_pulse[7:0] : per-key pulse on 1->0
//                   ("release" is a reserved word, hence the longer name)
//   unknown       : pulse when a valid byte maps to nothing
// ---------------------------------------------------------------------------
module key_tracker
    import key_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] key,
    output logic [7:0] press,
    output logic [7:0] release_pulse,
    output logic       unknown
);

    decode_t  dec;
    key_vec_t load_mask;
    logic     esc_hit;
    logic     unknown_hit;

    // Decode is purely combinational so the timers act on the same edge
    // that samples the byte; everything is gated by rx_valid.
    always_comb begin
        dec         = decode_byte(rx_data);
        load_mask   = '0;
        esc_hit     = 1'b0;
        unknown_hit = 1'b0;
        if (rx_valid) begin
            case (dec.kind)
                BYTE_KEY:     load_mask   = dec.mask;
                BYTE_ESC:     esc_hit     = 1'b1;
                default:      unknown_hit = 1'b1;
            endcase
        end
    end

    // One independent hold timer per key bit; ESC clears them all.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_timer
        key_hold_timer #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_timer (
            .clk           (clk),
            .reset         (reset),
            .load          (load_mask[k]),
            .clear         (esc_hit),
            .key           (key[k]),
            .press         (press[k]),
            .release_pulse (release_pulse[k])
        );
    end

    // Unknown flag is registered so it appears alongside the other outputs
    // for the same sampling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            unknown <= 1'b0;
        end else begin
            unknown <= unknown_hit;
        end
    end

endmodule
